clock_set_ctrl: RTL and testbench
=================================

// Module: clock_set_ctrl
// PURPOSE
//  Sequencer for the 12/24 h time counter. Generates its secs/mins/hours increment pulses.
//  - RUN: 1 Hz second tick from a clock prescaler.
//  - SET: user time-setting FSM with press/hold auto-repeat on the up button.
//  Sits between the synchronised front-panel buttons and the counter's HOURS/MINS/SECS inputs.
// PARAMETERS
//  TICK_DIV    50_000_000  clk cycles per second tick (>=2)
//  HOLD_CYC    25_000_000  cycles up_btn must be held, counted from the press edge, before auto-repeat starts
//  REPEAT_CYC   5_000_000  cycles between auto-repeat pulses (>=1)
//  BLINK_CYC   25_000_000  cycles per blink half-period in set modes
// PORTS
//  clk        in   1  system clock, all logic on posedge
//  reset      in   1  synchronous, active-high reset
//  mode_btn   in   1  mode button, already synchronised, 1 = pressed
//  up_btn     in   1  up button, already synchronised, 1 = pressed
//  secs_inc   out  1  one-cycle pulse -> counter SECS
//  mins_inc   out  1  one-cycle pulse -> counter MINS
//  hours_inc  out  1  one-cycle pulse -> counter HOURS
//  set_mode   out  2  00 RUN, 01 SET_HOUR, 10 SET_MIN (11 never driven)
//  blink      out  1  display blink enable for the field being set
// BEHAVIOUR
//  - Reset: all outputs 0, state RUN, all counters 0, both buttons disarmed.
//    A button is armed only after it is sampled low; a press held through reset is ignored until released.
//  - All outputs are registered. A press edge sampled at cycle N gives its pulse/state change at cycle N+1.
//  - FSM, advanced on each rising edge of mode_btn: RUN -> SET_HOUR -> SET_MIN -> RUN.
//  - Prescaler, RUN only:
//    - cnt counts 0..TICK_DIV-1 and wraps; secs_inc=1 in the cycle after cnt==TICK_DIV-1.
//    - In SET_* states cnt is held at 0 and secs_inc=0 (seconds frozen).
//    - Re-entering RUN restarts cnt from 0, so the first tick comes TICK_DIV cycles later.
//  - Up button, SET_* only:
//    - Rising edge -> one pulse on hours_inc (SET_HOUR) or mins_inc (SET_MIN).
//    - While held, the hold counter counts cycles since the edge.
//    - At HOLD_CYC -> repeat pulse, then one pulse every REPEAT_CYC until release.
//    - Release clears the hold counter immediately; no pulse after release.
//    - In RUN, up_btn is ignored entirely (no edge, no repeat).
//  - At most one of secs_inc/mins_inc/hours_inc is high in any cycle.
//  - Mode edge coincident with an up edge or repeat:
//    - The mode change wins; the up pulse is suppressed.
//    - up is disarmed until released (no carry-over into the new field).
//  - Mode change while up is held cancels the repeat the same way.
//  - blink:
//    - Set modes: 0 on entry to a SET_* state, toggles every BLINK_CYC cycles; its counter restarts on every mode change.
//    - RUN: blink=0.
//  - Reset mid-operation (any state, mid-repeat) returns to RUN at the next edge, with all outputs 0.
//  - Counter widths are $clog2 of their parameter. No counter ever exceeds its terminal value (no wrap beyond).
// STRUCTURE
//  - Package clock_ctrl_pkg:
//    - set_mode_e enum {RUN=2'b00, SET_HOUR=2'b01, SET_MIN=2'b10};
//    - width helper function for counter sizing.
//  - Sub-module btn_repeat (params HOLD_CYC, REPEAT_CYC; ports clk, reset, btn, enable, cancel -> pulse):
//    - arm/edge detect plus hold/repeat counter;
//    - one instance for up_btn.
//  - mode_btn uses plain arm + edge detect inside clock_set_ctrl.
//  - Prescaler, FSM and blink counter live in clock_set_ctrl.
// TESTING (TICK_DIV=10, HOLD_CYC=8, REPEAT_CYC=3, BLINK_CYC=5; cycle 0 = first cycle after reset drops)
//  1. Idle in RUN for 35 cycles -> secs_inc pulses at cycles 10, 20, 30 only;
//     set_mode=00, blink=0; mins_inc/hours_inc never high.
//  2. mode_btn pulse sampled at cycle 3 -> set_mode=01 at cycle 4; no secs_inc for the next 50 cycles;
//     blink 0 on entry, toggles every 5 cycles.
//  3. In SET_HOUR, up_btn high for cycles 0..18 (edge at 0) -> hours_inc at 1, 9, 12, 15, 18 only;
//     none after release; mins_inc stays 0.
//  4. In SET_HOUR, mode_btn and up_btn rise on the same cycle and up stays held 20 cycles
//     -> set_mode=10 next cycle; no inc pulses.
//     Release then re-press up -> exactly one mins_inc.
//  5. From SET_MIN, mode press at cycle N -> set_mode=00 at N+1, blink=0; first secs_inc at N+1+TICK_DIV.
//  6. up_btn held across reset deassertion in SET mode -> after reset set_mode=00 and no pulses;
//     reset asserted mid-repeat -> all outputs 0 at the next edge.
//     Random button stress: assert one-hot-or-zero on inc pulses every cycle.

Source files
------------

// File: rtl/clock_ctrl_pkg.sv
// Shared types and sizing helpers for the clock set/run sequencer.
package clock_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'b00,
        SET_HOUR = 2'b01,
        SET_MIN  = 2'b10
    } set_mode_e;

    // Bits needed for a counter running 0..v-1; never narrower than one bit.
    function automatic int cnt_w(input int v);
        return (v <= 1) ? 1 : $clog2(v);
    endfunction

endpackage

// File: rtl/btn_repeat.sv
// Press/hold auto-repeat for one synchronised button: one event on the press edge,
// then one after HOLD_CYC held cycles, then one every REPEAT_CYC cycles until release.
module btn_repeat
    import clock_ctrl_pkg::*;
#(
    parameter int HOLD_CYC   = 25_000_000,
    parameter int REPEAT_CYC = 5_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    input  logic enable,
    input  logic cancel,
    output logic pulse
);

    localparam int CW = cnt_w((HOLD_CYC > REPEAT_CYC) ? HOLD_CYC : REPEAT_CYC);
    localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYC - 1);
    localparam logic [CW-1:0] REP_LAST  = CW'(REPEAT_CYC - 1);

    logic          armed_q, armed_d;
    logic          active_q, active_d;
    logic          rep_q, rep_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // armed tracks "sampled low last cycle", so a press held through reset or a
    // cancel can only fire again after a release.
    always_comb begin
        armed_d  = ~btn;
        active_d = active_q;
        rep_d    = rep_q;
        cnt_d    = cnt_q;
        pulse    = 1'b0;
        if (!btn || !enable || cancel) begin
            active_d = 1'b0;
            rep_d    = 1'b0;
            cnt_d    = '0;
        end else if (armed_q) begin
            pulse    = 1'b1;
            active_d = 1'b1;
            rep_d    = 1'b0;
            cnt_d    = '0;
        end else if (active_q) begin
            if (cnt_q == (rep_q ? REP_LAST : HOLD_LAST)) begin
                pulse = 1'b1;
                rep_d = 1'b1;
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            armed_q  <= 1'b0;
            active_q <= 1'b0;
            rep_q    <= 1'b0;
            cnt_q    <= '0;
        end else begin
            armed_q  <= armed_d;
            active_q <= active_d;
            rep_q    <= rep_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: rtl/clock_set_ctrl.sv
// Run/set sequencer for the 12/24 h time counter: 1 Hz tick in RUN, button-driven
// hour/minute increments with auto-repeat in the set modes, plus the blink enable.
module clock_set_ctrl
    import clock_ctrl_pkg::*;
#(
    parameter int TICK_DIV   = 50_000_000,
    parameter int HOLD_CYC   = 25_000_000,
    parameter int REPEAT_CYC = 5_000_000,
    parameter int BLINK_CYC  = 25_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       mode_btn,
    input  logic       up_btn,
    output logic       secs_inc,
    output logic       mins_inc,
    output logic       hours_inc,
    output logic [1:0] set_mode,
    output logic       blink
);

    localparam int TW = cnt_w(TICK_DIV);
    localparam int BW = cnt_w(BLINK_CYC);
    localparam logic [TW-1:0] TICK_LAST  = TW'(TICK_DIV - 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_CYC - 1);

    set_mode_e     state_q, state_d;
    logic          mode_arm_q, mode_arm_d;
    logic [TW-1:0] tick_cnt_q, tick_cnt_d;
    logic [BW-1:0] blink_cnt_q, blink_cnt_d;
    logic          blink_q, blink_d;
    logic          secs_q, secs_d;
    logic          mins_q, mins_d;
    logic          hours_q, hours_d;
    logic          mode_edge;
    logic          up_en;
    logic          up_evt;

    assign mode_edge = mode_arm_q & mode_btn;
    assign up_en     = (state_q != RUN);

    btn_repeat #(
        .HOLD_CYC  (HOLD_CYC),
        .REPEAT_CYC(REPEAT_CYC)
    ) u_up_repeat (
        .clk   (clk),
        .reset (reset),
        .btn   (up_btn),
        .enable(up_en),
        .cancel(mode_edge),
        .pulse (up_evt)
    );

    always_comb begin
        state_d = state_q;
        if (mode_edge) begin
            case (state_q)
                RUN:      state_d = SET_HOUR;
                SET_HOUR: state_d = SET_MIN;
                default:  state_d = RUN;
            endcase
        end
    end

    // A mode edge restarts both the prescaler and the blink phase for the new state.
    always_comb begin
        mode_arm_d  = ~mode_btn;
        tick_cnt_d  = '0;
        secs_d      = 1'b0;
        blink_cnt_d = '0;
        blink_d     = 1'b0;
        if (state_q == RUN && !mode_edge) begin
            if (tick_cnt_q == TICK_LAST) begin
                secs_d = 1'b1;
            end else begin
                tick_cnt_d = tick_cnt_q + 1'b1;
            end
        end
        if (state_q != RUN && !mode_edge) begin
            blink_d = blink_q;
            if (blink_cnt_q == BLINK_LAST) begin
                blink_d = ~blink_q;
            end else begin
                blink_cnt_d = blink_cnt_q + 1'b1;
            end
        end
        hours_d = up_evt && (state_q == SET_HOUR);
        mins_d  = up_evt && (state_q == SET_MIN);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= RUN;
            mode_arm_q  <= 1'b0;
            tick_cnt_q  <= '0;
            blink_cnt_q <= '0;
            blink_q     <= 1'b0;
            secs_q      <= 1'b0;
            mins_q      <= 1'b0;
            hours_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            mode_arm_q  <= mode_arm_d;
            tick_cnt_q  <= tick_cnt_d;
            blink_cnt_q <= blink_cnt_d;
            blink_q     <= blink_d;
            secs_q      <= secs_d;
            mins_q      <= mins_d;
            hours_q     <= hours_d;
        end
    end

    assign secs_inc  = secs_q;
    assign mins_inc  = mins_q;
    assign hours_inc = hours_q;
    assign set_mode  = state_q;
    assign blink     = blink_q;

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Directed and randomised bench for clock_set_ctrl against an age-based behavioural model.
module tb_clock_set_ctrl;

    localparam int TICK  = 10;
    localparam int HOLD  = 8;
    localparam int REP   = 3;
    localparam int BLINK = 5;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       mode_btn = 1'b0;
    logic       up_btn = 1'b0;
    logic       secs_inc, mins_inc, hours_inc, blink;
    logic [1:0] set_mode;
    logic [5:0] dut_out;

    clock_set_ctrl #(
        .TICK_DIV  (TICK),
        .HOLD_CYC  (HOLD),
        .REPEAT_CYC(REP),
        .BLINK_CYC (BLINK)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .mode_btn (mode_btn),
        .up_btn   (up_btn),
        .secs_inc (secs_inc),
        .mins_inc (mins_inc),
        .hours_inc(hours_inc),
        .set_mode (set_mode),
        .blink    (blink)
    );

    always #5 clk = ~clk;

    // Bit layout: [5] blink, [4:3] set_mode, [2] hours, [1] mins, [0] secs
    assign dut_out = {blink, set_mode, hours_inc, mins_inc, secs_inc};

    int         n_vec = 0;
    int         n_bad = 0;
    int         idx = 0;
    logic [5:0] hist [0:63];

    // Model state: current mode, cycles spent in it, cycles since the up press edge.
    logic       m_valid = 1'b0;
    logic [5:0] exp_out = '0;
    int         m_mode = 0;
    int         m_age = 0;
    int         m_press = -1;
    logic       m_marm = 1'b0;
    logic       m_uarm = 1'b0;

    always @(posedge clk) begin : model_b
        logic medge;
        logic pulse;
        logic blink_e;
        int   pa;
        int   md;
        int   ma;
        if (reset) begin
            m_valid <= 1'b1;
            m_mode  <= 0;
            m_age   <= 0;
            m_press <= -1;
            m_marm  <= 1'b0;
            m_uarm  <= 1'b0;
            exp_out <= '0;
        end else begin
            medge = m_marm && mode_btn;
            pulse = 1'b0;
            pa    = m_press;
            if (medge || !up_btn || m_mode == 0) begin
                pa = -1;
            end else if (m_uarm) begin
                pa    = 0;
                pulse = 1'b1;
            end else if (pa >= 0) begin
                pa    = pa + 1;
                pulse = (pa == HOLD) || (pa > HOLD && ((pa - HOLD) % REP) == 0);
            end
            md      = medge ? (m_mode + 1) % 3 : m_mode;
            ma      = medge ? 0 : m_age + 1;
            blink_e = (md != 0) && (((ma / BLINK) % 2) == 1);
            exp_out <= {blink_e, 2'(md), pulse && (m_mode == 1), pulse && (m_mode == 2),
                        (m_mode == 0) && !medge && (((m_age + 1) % TICK) == 0)};
            m_mode  <= md;
            m_age   <= ma;
            m_press <= pa;
            m_marm  <= !mode_btn;
            m_uarm  <= !up_btn;
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_vec++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        idx++;
        if (idx < 64) hist[idx[5:0]] = dut_out;
        if (m_valid) check("model", 64'(dut_out), 64'(exp_out));
        check("onehot_inc", 64'($onehot0({hours_inc, mins_inc, secs_inc})), 64'd1);
    endtask

    task automatic start_window();
        idx = 0;
        for (int i = 0; i < 64; i++) hist[i] = '0;
        hist[0] = dut_out;
    endtask

    function automatic logic [63:0] mask(input int b);
        logic [63:0] m;
        for (int i = 0; i < 64; i++) m[i] = hist[i][b];
        return m;
    endfunction

    task automatic do_reset(input int n);
        reset = 1'b1;
        repeat (n) tick();
        reset = 1'b0;
    endtask

    task automatic press_mode();
        mode_btn = 1'b1;
        tick();
        mode_btn = 1'b0;
    endtask

    initial begin
        // Idle RUN: ticks at 10, 20, 30
        do_reset(3);
        check("reset_outputs", 64'(dut_out), 64'd0);
        start_window();
        repeat (35) tick();
        check("t1_secs", mask(0), 64'h0000_0000_4010_0400);
        check("t1_others", mask(1) | mask(2) | mask(3) | mask(4) | mask(5), 64'd0);

        // Enter SET_HOUR at cycle 4, seconds frozen, blink phase
        do_reset(2);
        start_window();
        repeat (3) tick();
        mode_btn = 1'b1;
        tick();
        mode_btn = 1'b0;
        check("t2_mode_before", 64'(hist[3][4:3]), 64'd0);
        check("t2_mode_after", 64'(hist[4][4:3]), 64'd1);
        repeat (50) tick();
        check("t2_no_secs", mask(0), 64'd0);
        check("t2_blink", 64'({hist[4][5], hist[8][5], hist[9][5], hist[13][5], hist[14][5], hist[19][5]}),
              64'b001101);

        // Hold up in SET_HOUR for cycles 0..18
        up_btn = 1'b1;
        start_window();
        repeat (18) tick();
        up_btn = 1'b0;
        repeat (13) tick();
        check("t3_hours", mask(2), 64'h0000_0000_0004_9202);
        check("t3_mins", mask(1), 64'd0);

        // Mode and up together: mode wins, up disarmed until released
        repeat (2) tick();
        start_window();
        mode_btn = 1'b1;
        up_btn   = 1'b1;
        tick();
        mode_btn = 1'b0;
        check("t4_mode", 64'(hist[1][4:3]), 64'd2);
        repeat (19) tick();
        up_btn = 1'b0;
        repeat (3) tick();
        up_btn = 1'b1;
        repeat (2) tick();
        up_btn = 1'b0;
        repeat (3) tick();
        check("t4_hours", mask(2), 64'd0);
        check("t4_mins", mask(1), 64'h0000_0000_0100_0000);

        // Back to RUN: prescaler restarts
        repeat (2) tick();
        start_window();
        press_mode();
        check("t5_mode_blink", 64'(hist[1][5:3]), 64'd0);
        repeat (24) tick();
        check("t5_secs", mask(0), 64'h0000_0000_0020_0800);

        // up held across reset
        press_mode();
        repeat (3) tick();
        up_btn = 1'b1;
        repeat (2) tick();
        reset = 1'b1;
        repeat (2) tick();
        reset = 1'b0;
        start_window();
        repeat (20) tick();
        check("t6_held_reset", mask(1) | mask(2) | mask(3) | mask(4) | mask(5), 64'd0);
        up_btn = 1'b0;
        tick();

        // Reset in the middle of auto-repeat
        press_mode();
        repeat (2) tick();
        up_btn = 1'b1;
        start_window();
        repeat (14) tick();
        check("t6_pre_reset_hours", mask(2), 64'h0000_0000_0000_1202);
        reset = 1'b1;
        tick();
        check("t6_reset_outputs", 64'(dut_out), 64'd0);
        reset  = 1'b0;
        up_btn = 1'b0;
        tick();

        // Random button stress
        for (int i = 0; i < 600; i++) begin
            mode_btn = mode_btn ? 1'b0 : ($urandom_range(0, 24) == 0);
            if ($urandom_range(0, 7) == 0) up_btn = ~up_btn;
            reset = ($urandom_range(0, 249) == 0);
            tick();
        end
        reset = 1'b0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
